hazard_scoreboard: RTL

//  Register-file hazard controller between ID, the two writeback sources (EX, MEM/load) and g_register.

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/hazard_scoreboard_wb_arbiter.sv | 32 +++
 rtl/hazard_scoreboard.sv | 86 ++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing for the register-file hazard scoreboard and its writeback arbiter.
package hazard_scoreboard_pkg;
  localparam int NREG       = 16;
  localparam int RNUM_W     = 4;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 4;

  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;
endpackage

// File: rtl/hazard_scoreboard_wb_arbiter.sv
// EX-priority arbiter for the single RF write port, with a MEM starvation guard.
module wb_arbiter
  import hazard_scoreboard_pkg::*;
#(
  parameter int STARVE_MAX = hazard_scoreboard_pkg::STARVE_MAX
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    ex_wb,
  input  logic    mem_wb,
  output logic    ex_ready,
  output logic    mem_ready,
  output wb_src_e sel
);
  logic [CNT_W-1:0] starve_cnt;
  logic             mem_force;

  assign mem_force = (starve_cnt == CNT_W'(STARVE_MAX));
  assign mem_ready = mem_wb & (~ex_wb | mem_force);
  assign ex_ready  = ex_wb & ~mem_ready;
  assign sel       = mem_ready ? SRC_MEM : SRC_EX;

  // Counts consecutive cycles in which a held MEM request lost to EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (mem_wb & ~mem_ready)
      starve_cnt <= mem_force ? starve_cnt : starve_cnt + CNT_W'(1);
    else
      starve_cnt <= '0;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-GPR reservation scoreboard: ID stall on RAW/WAW, EX/MEM writeback merge, retire on RF commit.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG       = hazard_scoreboard_pkg::NREG,
  parameter int RNUM_W     = hazard_scoreboard_pkg::RNUM_W,
  parameter int DATA_W     = hazard_scoreboard_pkg::DATA_W,
  parameter int STARVE_MAX = hazard_scoreboard_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [RNUM_W-1:0] id_r0_num_i,
  input  logic              id_r0_use_i,
  input  logic [RNUM_W-1:0] id_r1_num_i,
  input  logic              id_r1_use_i,
  input  logic              id_w_reserve_i,
  input  logic [RNUM_W-1:0] id_rd_num_i,
  output logic              id_stall_o,
  input  logic              ex_wb_i,
  input  logic [RNUM_W-1:0] ex_rd_num_i,
  input  logic [DATA_W-1:0] ex_rd_data_i,
  output logic              ex_ready_o,
  input  logic              mem_wb_i,
  input  logic [RNUM_W-1:0] mem_rd_num_i,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              mem_ready_o,
  output logic              rf_we_o,
  output logic [RNUM_W-1:0] rf_num_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic [NREG-1:0]   reserved_o,
  output logic              err_o
);
  logic [NREG-1:0]   res, res_set, res_clr;
  logic              issue, gnt, err_hit;
  logic [RNUM_W-1:0] gnt_num;
  logic [DATA_W-1:0] gnt_data;
  wb_src_e           sel;

  wb_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .ex_wb     (ex_wb_i),
    .mem_wb    (mem_wb_i),
    .ex_ready  (ex_ready_o),
    .mem_ready (mem_ready_o),
    .sel       (sel)
  );

  // Registered reservations only; a write retiring this cycle still stalls ID.
  assign id_stall_o = id_valid_i & ((id_r0_use_i & res[id_r0_num_i]) |
                                    (id_r1_use_i & res[id_r1_num_i]) |
                                    (id_w_reserve_i & res[id_rd_num_i]));
  assign issue      = id_valid_i & ~id_stall_o & id_w_reserve_i;

  assign gnt      = ex_ready_o | mem_ready_o;
  assign gnt_num  = (sel == SRC_MEM) ? mem_rd_num_i  : ex_rd_num_i;
  assign gnt_data = (sel == SRC_MEM) ? mem_rd_data_i : ex_rd_data_i;

  assign res_set = issue   ? (NREG'(1) << id_rd_num_i) : '0;
  assign res_clr = rf_we_o ? (NREG'(1) << rf_num_o)    : '0;

  assign err_hit = (gnt & ~res[gnt_num]) |
                   (ex_wb_i & mem_wb_i & (ex_rd_num_i == mem_rd_num_i));

  // Set is applied after clear so a same-bit collision leaves the bit reserved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res       <= '0;
      rf_we_o   <= 1'b0;
      rf_num_o  <= '0;
      rf_data_o <= '0;
      err_o     <= 1'b0;
    end else begin
      res     <= (res & ~res_clr) | res_set;
      rf_we_o <= gnt;
      if (gnt) begin
        rf_num_o  <= gnt_num;
        rf_data_o <= gnt_data;
      end
      if (err_hit) err_o <= 1'b1;
    end
  end

  assign reserved_o = res;
endmodule
